// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// ALU control codes, ALU operation class and controller state.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11
   } state_t;

endpackage

// File: rtl/mc_controller_if.sv
// Control bundle between the controller (master) and the datapath (slave).
interface mc_controller_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;
   logic       illegal;

   modport master (
      input  op, funct, zero,
      output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
             alusrca, alusrcb, pcsrc, alucontrol, illegal
   );

   modport slave (
      output op, funct, zero,
      input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
             alusrca, alusrcb, pcsrc, alucontrol, illegal
   );
endinterface

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps operation class and funct field to an ALU control code.
module aludec
   import mips_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol,
   output logic       funct_bad
);

   // unknown functs fall back to add and raise funct_bad for the controller
   always_comb begin
      alucontrol = ALU_ADD;
      funct_bad  = 1'b0;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: funct_bad  = 1'b1;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit.
//
//   state   | meaning
//   FETCH   | read instruction, PC <= PC + 4
//   DECODE  | register read, branch target into ALUOut, dispatch on op
//   MEMADR  | effective address for lw/sw
//   MEMRD   | data memory read
//   MEMWB   | load data into rt
//   MEMWR   | data memory write
//   RTYPEEX | ALU op selected by funct
//   RTYPEWB | ALU result into rd
//   BEQEX   | compare, PC <= ALUOut when taken (beq or bne)
//   ADDIEX  | register + sign-extended immediate
//   ADDIWB  | ALU result into rt
//   JEX     | PC <= jump target
module mc_controller
   import mips_pkg::*;
#(
   parameter bit ENABLE_BNE = 1'b1
)
(
   input  logic              clk,
   input  logic              reset,
   mc_controller_if.master   bus
);

   state_t     state_q, state_d;
   logic       is_bne_q, is_bne_d;
   logic       is_sw_q, is_sw_d;

   logic       pcwrite, branch, illegal_raw;
   logic       memwrite_raw, irwrite_raw, regwrite_raw;
   logic       iord_raw, memtoreg_raw, regdst_raw, alusrca_raw;
   logic [1:0] alusrcb_raw, pcsrc_raw;
   aluop_t     aluop;
   logic [2:0] alucontrol;
   logic       funct_bad;

   // ALU operation class depends on state only; reset pins it to add
   assign aluop = reset                  ? ALUOP_ADD   :
                  (state_q == S_RTYPEEX) ? ALUOP_FUNCT :
                  (state_q == S_BEQEX)   ? ALUOP_SUB   : ALUOP_ADD;

   aludec u_aludec (
      .aluop      (aluop),
      .funct      (bus.funct),
      .alucontrol (alucontrol),
      .funct_bad  (funct_bad)
   );

   // next-state and Moore decode of the current state
   always_comb begin
      state_d      = S_FETCH;
      is_bne_d     = is_bne_q;
      is_sw_d      = is_sw_q;
      pcwrite      = 1'b0;
      branch       = 1'b0;
      illegal_raw  = 1'b0;
      memwrite_raw = 1'b0;
      irwrite_raw  = 1'b0;
      regwrite_raw = 1'b0;
      iord_raw     = 1'b0;
      memtoreg_raw = 1'b0;
      regdst_raw   = 1'b0;
      alusrca_raw  = 1'b0;
      alusrcb_raw  = 2'b00;
      pcsrc_raw    = 2'b00;
      case (state_q)
         S_FETCH: begin
            alusrcb_raw = 2'b01;
            irwrite_raw = 1'b1;
            pcwrite     = 1'b1;
            state_d     = S_DECODE;
         end
         S_DECODE: begin
            alusrcb_raw = 2'b11;
            is_bne_d    = 1'b0;
            is_sw_d     = (bus.op == OP_SW);
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_BNE: begin
                  if (ENABLE_BNE) begin
                     state_d  = S_BEQEX;
                     is_bne_d = 1'b1;
                  end else begin
                     illegal_raw = 1'b1;
                  end
               end
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
               default:      illegal_raw = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alusrca_raw = 1'b1;
            alusrcb_raw = 2'b10;
            state_d     = is_sw_q ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            iord_raw = 1'b1;
            state_d  = S_MEMWB;
         end
         S_MEMWB: begin
            memtoreg_raw = 1'b1;
            regwrite_raw = 1'b1;
         end
         S_MEMWR: begin
            iord_raw     = 1'b1;
            memwrite_raw = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca_raw = 1'b1;
            illegal_raw = funct_bad;
            state_d     = funct_bad ? S_FETCH : S_RTYPEWB;
         end
         S_RTYPEWB: begin
            regdst_raw   = 1'b1;
            regwrite_raw = 1'b1;
         end
         S_BEQEX: begin
            alusrca_raw = 1'b1;
            pcsrc_raw   = 2'b01;
            branch      = 1'b1;
         end
         S_ADDIEX: begin
            alusrca_raw = 1'b1;
            alusrcb_raw = 2'b10;
            state_d     = S_ADDIWB;
         end
         S_ADDIWB: regwrite_raw = 1'b1;
         S_JEX: begin
            pcsrc_raw = 2'b10;
            pcwrite   = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // reset overrides every strobe and select so nothing commits while held
   always_comb begin
      bus.pcen       = ~reset & (pcwrite | (branch & (bus.zero ^ is_bne_q)));
      bus.memwrite   = ~reset & memwrite_raw;
      bus.irwrite    = ~reset & irwrite_raw;
      bus.regwrite   = ~reset & regwrite_raw;
      bus.illegal    = ~reset & illegal_raw;
      bus.iord       = ~reset & iord_raw;
      bus.memtoreg   = ~reset & memtoreg_raw;
      bus.regdst     = ~reset & regdst_raw;
      bus.alusrca    = ~reset & alusrca_raw;
      bus.alusrcb    = reset ? 2'b00 : alusrcb_raw;
      bus.pcsrc      = reset ? 2'b00 : pcsrc_raw;
      bus.alucontrol = alucontrol;
   end

   // state and the two instruction-class bits captured in DECODE
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_FETCH;
         is_bne_q <= 1'b0;
         is_sw_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         is_bne_q <= is_bne_d;
         is_sw_q  <= is_sw_d;
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: each step drives op/funct/zero/reset and
// carries the expected control vector, which is checked half a cycle later.
module tb_mc_controller;
   import mips_pkg::*;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic [5:0] funct;
      logic       zero;
      logic [15:0] exp;
   } step_t;

   localparam logic [5:0] GO = 6'b111111;
   localparam logic [5:0] GF = 6'b000000;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic done;

   step_t       stim_q[$];
   string       stag_q[$];
   logic [15:0] exp_q[$];
   string       tag_q[$];

   mc_controller_if bus();

   mc_controller #(.ENABLE_BNE(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [15:0] obs;
   assign obs = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord,
                 bus.memtoreg, bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc,
                 bus.alucontrol, bus.illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mk(input logic pcen, input logic mw,
      input logic irw, input logic rw, input logic iord, input logic m2r,
      input logic rdst, input logic asa, input logic [1:0] asb,
      input logic [1:0] pcs, input logic [2:0] alu, input logic ill);
      return {pcen, mw, irw, rw, iord, m2r, rdst, asa, asb, pcs, alu, ill};
   endfunction

   function automatic logic [15:0] v_rst();
      return mk(0,0,0,0,0,0,0,0,2'b00,2'b00,3'b010,0);
   endfunction
   function automatic logic [15:0] v_fetch();
      return mk(1,0,1,0,0,0,0,0,2'b01,2'b00,3'b010,0);
   endfunction
   function automatic logic [15:0] v_decode(input logic ill);
      return mk(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,ill);
   endfunction
   function automatic logic [15:0] v_memadr();
      return mk(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0);
   endfunction

   task automatic check_vec(input logic [15:0] e, input string tt);
      checks++;
      if (obs !== e) begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tt, obs, e);
      end
   endtask

   task automatic push(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic [15:0] e, input string t);
      step_t s;
      s.rst = r; s.op = o; s.funct = f; s.zero = z; s.exp = e;
      stim_q.push_back(s);
      stag_q.push_back(t);
   endtask

   task automatic t_lw();
      push(0, GO, GF, 1, v_fetch(), "lw_fetch");
      push(0, OP_LW, GF, 1, v_decode(0), "lw_decode");
      push(0, OP_SW, GF, 1, v_memadr(), "lw_memadr");
      push(0, OP_SW, GF, 1, mk(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b010,0), "lw_memrd");
      push(0, OP_SW, GF, 1, mk(0,0,0,1,0,1,0,0,2'b00,2'b00,3'b010,0), "lw_memwb");
   endtask

   task automatic t_sw();
      push(0, GO, GF, 1, v_fetch(), "sw_fetch");
      push(0, OP_SW, GF, 1, v_decode(0), "sw_decode");
      push(0, OP_LW, GF, 1, v_memadr(), "sw_memadr");
      push(0, OP_LW, GF, 1, mk(0,1,0,0,1,0,0,0,2'b00,2'b00,3'b010,0), "sw_memwr");
   endtask

   task automatic t_rtype(input logic [5:0] f, input logic [2:0] alu,
                          input logic bad, input string t);
      push(0, GO, GF, 1, v_fetch(), {t, "_fetch"});
      push(0, OP_RTYPE, GF, 1, v_decode(0), {t, "_decode"});
      push(0, GO, f, 1, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,alu,bad), {t, "_ex"});
      if (!bad)
         push(0, GO, GF, 1, mk(0,0,0,1,0,0,1,0,2'b00,2'b00,3'b010,0), {t, "_wb"});
   endtask

   task automatic t_branch(input logic bne, input logic z, input string t);
      logic [5:0] o;
      logic [5:0] other;
      o     = bne ? OP_BNE : OP_BEQ;
      other = bne ? OP_BEQ : OP_BNE;
      push(0, GO, GF, 1, v_fetch(), {t, "_fetch"});
      push(0, o, GF, 1, v_decode(0), {t, "_decode"});
      push(0, other, GF, z,
           mk(bne ? ~z : z,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0), {t, "_ex"});
   endtask

   task automatic t_addi();
      push(0, GO, GF, 1, v_fetch(), "addi_fetch");
      push(0, OP_ADDI, GF, 1, v_decode(0), "addi_decode");
      push(0, GO, GF, 1, v_memadr(), "addi_ex");
      push(0, GO, GF, 1, mk(0,0,0,1,0,0,0,0,2'b00,2'b00,3'b010,0), "addi_wb");
   endtask

   task automatic t_j();
      push(0, GO, GF, 1, v_fetch(), "j_fetch");
      push(0, OP_J, GF, 1, v_decode(0), "j_decode");
      push(0, GO, GF, 1, mk(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0), "j_ex");
   endtask

   task automatic t_illegal_op(input logic [5:0] o);
      push(0, GO, GF, 1, v_fetch(), "ill_fetch");
      push(0, o, GF, 1, v_decode(1), "ill_decode");
   endtask

   initial begin
      done = 1'b0;
      #20000;
      if (!done) begin
         errors++;
         $error("FAIL timeout: step sequence did not complete");
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   initial begin
      step_t       s;
      string       t;
      logic [15:0] e;
      string       tt;
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      bus.op    = GO;
      bus.funct = GF;
      bus.zero  = 1'b0;

      @(negedge clk);
      check_vec(v_rst(), "rst_state");

      push(1, GO, GF, 0, v_rst(), "rst_init0");
      push(1, GO, GF, 1, v_rst(), "rst_init1");
      push(0, GO, GF, 1, v_fetch(), "radd_fetch");
      push(0, OP_RTYPE, GF, 1, v_decode(0), "radd_decode");
      push(1, GO, FN_ADD, 1, v_rst(), "rst_mid_rtypeex");
      push(1, GO, FN_ADD, 1, v_rst(), "rst_hold1");
      push(1, GO, FN_ADD, 1, v_rst(), "rst_hold2");
      t_lw();
      t_rtype(FN_SLT, ALU_SLT, 0, "slt");
      t_branch(0, 1, "beq_z1");
      t_branch(0, 0, "beq_z0");
      t_branch(1, 0, "bne_z0");
      t_branch(1, 1, "bne_z1");
      t_illegal_op(GO);
      t_rtype(GF, ALU_ADD, 1, "rbad");
      t_sw();
      t_j();
      t_addi();
      t_rtype(FN_SUB, ALU_SUB, 0, "sub");
      t_rtype(FN_AND, ALU_AND, 0, "and");
      t_rtype(FN_OR, ALU_OR, 0, "or");
      t_rtype(FN_ADD, ALU_ADD, 0, "add");
      push(0, GO, GF, 1, v_fetch(), "final_fetch");

      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         t = stag_q.pop_front();
         @(posedge clk);
         #1;
         reset     = s.rst;
         bus.op    = s.op;
         bus.funct = s.funct;
         bus.zero  = s.zero;
         exp_q.push_back(s.exp);
         tag_q.push_back(t);
         @(negedge clk);
         e  = exp_q.pop_front();
         tt = tag_q.pop_front();
         check_vec(e, tt);
      end

      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
